mp_dcache_data_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port 16x256 dcache data SRAM (byte write mask, 32 lanes).
- Requester A is the CPU hit path (word/byte reads and writes). Requester B is the line fill/writeback engine (full-line reads and writes).
- Issues at most one SRAM access per cycle and drives the SRAM chip-select, write-enable, mask, address and data.
- Returns read data to the requester that issued the read, one cycle after grant.

---
 rtl/mp_dcache_data_arbiter.sv | 124 ++++++++++++
 tb/tb_mp_dcache_data_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_dcache_data_arbiter.sv
// Two-requester arbiter/sequencer for the single-port 16x256 dcache data SRAM.
// Optional macro MP_DCACHE_ARB_RDATA_HOLD_EN registers read data so it stays stable between responses.
module mp_dcache_data_arbiter #(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 4,
  parameter int NUM_WMASKS   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk0,
  input  logic                  rst_n,

  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,

  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,

  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam logic [8:0] LIMIT = 9'(STARVE_LIMIT);

  logic [7:0] starve_q, starve_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_owner_q, rsp_owner_d;
  logic       a_win;

  // A overrides B once it has been denied for LIMIT consecutive cycles.
  always_comb begin
    a_win = a_req && (!b_req || ({1'b0, starve_q} >= LIMIT));
    a_gnt = rst_n && a_win;
    b_gnt = rst_n && b_req && !a_win;
  end

  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (a_gnt) begin
      sram_csb   = 1'b0;
      sram_web   = ~a_we;
      sram_wmask = a_we ? a_wmask : '0;
      sram_addr  = a_addr;
      sram_din   = a_wdata;
    end else if (b_gnt) begin
      sram_csb   = 1'b0;
      sram_web   = ~b_we;
      sram_wmask = b_we ? b_wmask : '0;
      sram_addr  = b_addr;
      sram_din   = b_wdata;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!a_req || a_gnt) begin
      starve_d = 8'd0;
    end else if (starve_q != 8'hFF) begin
      starve_d = starve_q + 8'd1;
    end
    rsp_valid_d = (a_gnt && !a_we) || (b_gnt && !b_we);
    rsp_owner_d = b_gnt;
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      starve_q    <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  // Gating with rst_n drops a response whose read was granted just before reset.
  always_comb begin
    a_rvalid = rst_n && rsp_valid_q && !rsp_owner_q;
    b_rvalid = rst_n && rsp_valid_q &&  rsp_owner_q;
  end

`ifdef MP_DCACHE_ARB_RDATA_HOLD_EN
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rsp_valid_q) begin
      rdata_q <= sram_dout;
    end
  end

  always_comb begin
    a_rdata = (a_rvalid || b_rvalid) ? sram_dout : rdata_q;
    b_rdata = a_rdata;
  end
`else
  always_comb begin
    a_rdata = sram_dout;
    b_rdata = sram_dout;
  end
`endif

endmodule

// File: tb/tb_mp_dcache_data_arbiter.sv
// Scoreboard bench for mp_dcache_data_arbiter with a behavioural negedge-write SRAM model.
module tb_mp_dcache_data_arbiter;
  localparam int DW = 256;
  localparam int AW = 4;
  localparam int MW = 32;
  localparam logic [DW-1:0] JUNK = {8{32'hDEADBEEF}};

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [MW-1:0] a_wmask, b_wmask;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          sram_csb, sram_web;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;

  mp_dcache_data_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(MW), .STARVE_LIMIT(4)
  ) dut (
    .clk0(clk0), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wmask(a_wmask), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wmask(b_wmask), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // SRAM model: capture on posedge, write/read on the following negedge.
  logic [DW-1:0] mem [16];
  logic          cap_en = 1'b0, cap_we = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic [MW-1:0] cap_mask = '0;
  logic [DW-1:0] cap_din = '0;

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk0) begin
    cap_en   <= !sram_csb;
    cap_we   <= !sram_web;
    cap_addr <= sram_addr;
    cap_mask <= sram_wmask;
    cap_din  <= sram_din;
  end

  always @(negedge clk0) begin
    if (cap_en && cap_we)
      for (int i = 0; i < MW; i++)
        if (cap_mask[i]) mem[cap_addr][i*8 +: 8] <= cap_din[i*8 +: 8];
    if (cap_en && !cap_we) sram_dout <= mem[cap_addr];
    else                   sram_dout <= JUNK;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk0) cyc++;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            due;
    bit            owner;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  // Monitor: a due entry must be answered by its owner; otherwise no rvalid at all.
  always begin
    exp_t e;
    @(negedge clk0);
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp_valid_ab", {254'd0, a_rvalid, b_rvalid}, e.owner ? 256'd1 : 256'd2);
      chk("rsp_data", e.owner ? b_rdata : a_rdata, e.data);
    end else begin
      chk("no_rvalid", {254'd0, a_rvalid, b_rvalid}, '0);
    end
  end

  logic [DW-1:0] exp_rd_a, exp_rd_b;

  task automatic nxt();
    @(posedge clk0);
    #1;
  endtask

  task automatic gnt(input logic ea, input logic eb, input logic rsp);
    @(negedge clk0);
    #1;
    chk("a_gnt", {255'd0, a_gnt}, {255'd0, ea});
    chk("b_gnt", {255'd0, b_gnt}, {255'd0, eb});
    if (rsp && ea) sb.push_back('{cyc + 1, 1'b0, exp_rd_a});
    if (rsp && eb) sb.push_back('{cyc + 1, 1'b1, exp_rd_b});
  endtask

  task automatic chk_sram_idle();
    chk("idle_csb", {255'd0, sram_csb}, 256'd1);
    chk("idle_web", {255'd0, sram_web}, 256'd1);
    chk("idle_wmask", {224'd0, sram_wmask}, '0);
    chk("idle_addr", {252'd0, sram_addr}, '0);
    chk("idle_din", sram_din, '0);
  endtask

  task automatic clr_req();
    a_req = 0; a_we = 0; a_addr = '0; a_wmask = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wmask = '0; b_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr_req();
    rst_n = 0;
    a_req = 1; a_we = 1; b_req = 1; b_we = 1;
    a_wmask = '1; b_wmask = '1; a_addr = 4'd5; b_addr = 4'd6;
    for (int i = 0; i < 3; i++) begin
      gnt(0, 0, 0);
      chk("rst_csb", {255'd0, sram_csb}, 256'd1);
      chk("rst_web", {255'd0, sram_web}, 256'd1);
`ifdef MP_DCACHE_ARB_RDATA_HOLD_EN
      if (i > 0) chk("rst_rdata", a_rdata, '0);
`endif
      nxt();
    end
    rst_n = 1;
    clr_req();

    for (int i = 0; i < 10; i++) begin
      gnt(0, 0, 0);
      chk_sram_idle();
      nxt();
    end

    // B writes A5 line to set 3; A reads it back the following cycle.
    b_req = 1; b_we = 1; b_addr = 4'd3; b_wmask = '1; b_wdata = {32{8'hA5}};
    gnt(0, 1, 0);
    chk("wr_web", {255'd0, sram_web}, '0);
    chk("wr_wmask", {224'd0, sram_wmask}, {224'd0, 32'hFFFF_FFFF});
    nxt();
    clr_req();
    a_req = 1; a_we = 0; a_addr = 4'd3; exp_rd_a = {32{8'hA5}};
    gnt(1, 0, 1);
    chk("rd_addr", {252'd0, sram_addr}, 256'd3);
    nxt();
    clr_req();

    // Zero-mask write is issued but leaves the line untouched.
    a_req = 1; a_we = 1; a_addr = 4'd3; a_wmask = '0; a_wdata = '0;
    gnt(1, 0, 0);
    chk("zmask_csb", {255'd0, sram_csb}, '0);
    chk("zmask_web", {255'd0, sram_web}, '0);
    nxt();
    a_we = 0;
    gnt(1, 0, 1);
    nxt();
    clr_req();

    // Prefill set 7 with FF and set 2 with 11, then byte-0 write on set 7.
    b_req = 1; b_we = 1; b_wmask = '1; b_addr = 4'd7; b_wdata = {32{8'hFF}};
    gnt(0, 1, 0);
    nxt();
    b_addr = 4'd2; b_wdata = {32{8'h11}};
    gnt(0, 1, 0);
    nxt();
    clr_req();
    a_req = 1; a_we = 1; a_addr = 4'd7; a_wmask = 32'h0000_0001; a_wdata = {248'd0, 8'h3C};
    gnt(1, 0, 0);
    chk("bw_wmask", {224'd0, sram_wmask}, 256'd1);
    nxt();
    a_we = 0; a_wmask = '1; exp_rd_a = {{31{8'hFF}}, 8'h3C};
    gnt(1, 0, 1);
    chk("rd_wmask_zero", {224'd0, sram_wmask}, '0);
    nxt();
    clr_req();

    // Starvation: B wins 4 conflicts, A wins the 5th, then B resumes.
    exp_rd_a = {32{8'hA5}}; exp_rd_b = {32{8'h11}};
    a_req = 1; a_addr = 4'd3; b_req = 1; b_addr = 4'd2;
    for (int i = 0; i < 4; i++) begin
      gnt(0, 1, 1);
      nxt();
    end
    gnt(1, 0, 1);
    nxt();
    a_req = 0;
    gnt(0, 1, 1);
    nxt();

    // Dropping a_req clears the count, so B gets a full 4 wins again.
    a_req = 1;
    for (int i = 0; i < 2; i++) begin
      gnt(0, 1, 1);
      nxt();
    end
    a_req = 0;
    gnt(0, 1, 1);
    nxt();
    a_req = 1;
    for (int i = 0; i < 4; i++) begin
      gnt(0, 1, 1);
      nxt();
    end
    gnt(1, 0, 1);
    nxt();
    clr_req();
    nxt();

    // Read granted, then reset asserted the next cycle: no response.
    a_req = 1; a_we = 0; a_addr = 4'd1;
    gnt(1, 0, 0);
    nxt();
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      gnt(0, 0, 0);
      chk("rstrd_csb", {255'd0, sram_csb}, 256'd1);
      chk("rstrd_a_rvalid", {255'd0, a_rvalid}, '0);
      nxt();
    end
    rst_n = 1;
    clr_req();
    nxt();

    // B reads set 2; with hold enabled the line persists through idle cycles.
    b_req = 1; b_we = 0; b_addr = 4'd2; exp_rd_b = {32{8'h11}};
    gnt(0, 1, 1);
    nxt();
    clr_req();
`ifdef MP_DCACHE_ARB_RDATA_HOLD_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk0);
      #1;
      chk("hold_b_rdata", b_rdata, {32{8'h11}});
      nxt();
    end
`else
    nxt();
`endif

    for (int i = 0; i < 3; i++) nxt();
    chk("sb_empty", 256'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
